// File: rtl/cpu_controller.sv
// cpu_controller: instruction register and control FSM driving every datapath control input
module cpu_controller #(
  parameter int IW    = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IW-1:0]            in,
  input  logic                     load,
  input  logic                     s,
  output logic                     w,
  output logic [$clog2(NREGS)-1:0] readnum,
  output logic [$clog2(NREGS)-1:0] writenum,
  output logic                     write,
  output logic                     vsel,
  output logic                     loada,
  output logic                     loadb,
  output logic                     asel,
  output logic                     bsel,
  output logic                     loadc,
  output logic                     loads,
  output logic [1:0]               shift,
  output logic [1:0]               ALUop,
  output logic [IW-1:0]            datapath_in
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_REG
  } state_t;

  state_t          r_st;
  state_t          w_nxt;
  logic [IW-1:0]   r_ir;
  logic            r_w;
  logic [RW-1:0]   r_readnum;
  logic [RW-1:0]   r_writenum;
  logic            r_write;
  logic            r_vsel;
  logic            r_loada;
  logic            r_loadb;
  logic            r_asel;
  logic            r_loadc;
  logic            r_loads;
  logic [1:0]      r_shift;
  logic [1:0]      r_alu_op;

  logic [RW-1:0]   w_rn;
  logic [RW-1:0]   w_rd;
  logic [RW-1:0]   w_rm;
  logic [1:0]      w_sh;
  logic [1:0]      w_op;
  logic            w_alu_cls;
  logic            w_mov_cls;
  logic            w_mov_imm;
  logic            w_mov_reg;
  logic            w_cmp;
  logic            w_mvn;

  assign w_rn      = r_ir[10:8];
  assign w_rd      = r_ir[7:5];
  assign w_sh      = r_ir[4:3];
  assign w_rm      = r_ir[2:0];
  assign w_op      = r_ir[12:11];
  assign w_alu_cls = r_ir[15:13] == 3'b101;
  assign w_mov_cls = r_ir[15:13] == 3'b110;
  assign w_mov_imm = w_mov_cls && w_op == 2'b10;
  assign w_mov_reg = w_mov_cls && w_op == 2'b00;
  assign w_cmp     = w_alu_cls && w_op == 2'b01;
  assign w_mvn     = w_alu_cls && w_op == 2'b11;

  // Next-state decode; IR is stable outside WAIT, so its fields are valid wherever they are used
  always_comb begin
    w_nxt = S_WAIT;
    case (r_st)
      S_WAIT:   w_nxt = s ? S_DECODE : S_WAIT;
      S_DECODE: w_nxt = w_mov_imm ? S_WR_IMM :
                        (w_mov_reg || w_mvn) ? S_GET_B :
                        w_alu_cls ? S_GET_A : S_WAIT;
      S_GET_A:  w_nxt = S_GET_B;
      S_GET_B:  w_nxt = S_ALU;
      S_ALU:    w_nxt = w_cmp ? S_WAIT : S_WR_REG;
      default:  w_nxt = S_WAIT;
    endcase
  end

  // State, IR and registered Moore outputs computed for the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st       <= S_WAIT;
      r_ir       <= '0;
      r_w        <= 1'b1;
      r_readnum  <= '0;
      r_writenum <= '0;
      r_write    <= 1'b0;
      r_vsel     <= 1'b0;
      r_loada    <= 1'b0;
      r_loadb    <= 1'b0;
      r_asel     <= 1'b0;
      r_loadc    <= 1'b0;
      r_loads    <= 1'b0;
      r_shift    <= 2'b00;
      r_alu_op   <= 2'b00;
    end else begin
      r_st       <= w_nxt;
      if (r_st == S_WAIT && load) r_ir <= in;
      r_w        <= w_nxt == S_WAIT;
      r_readnum  <= w_nxt == S_GET_A ? w_rn : w_nxt == S_GET_B ? w_rm : '0;
      r_writenum <= w_nxt == S_WR_IMM ? w_rn : w_nxt == S_WR_REG ? w_rd : '0;
      r_write    <= w_nxt == S_WR_IMM || w_nxt == S_WR_REG;
      r_vsel     <= w_nxt == S_WR_IMM;
      r_loada    <= w_nxt == S_GET_A;
      r_loadb    <= w_nxt == S_GET_B;
      r_asel     <= w_nxt == S_ALU && (w_mov_reg || w_mvn);
      r_loadc    <= w_nxt == S_ALU && !w_cmp;
      r_loads    <= w_nxt == S_ALU;
      r_shift    <= w_nxt == S_ALU ? w_sh : 2'b00;
      r_alu_op   <= w_nxt == S_ALU ? w_op : 2'b00;
    end
  end

  assign w           = r_w;
  assign readnum     = r_readnum;
  assign writenum    = r_writenum;
  assign write       = r_write;
  assign vsel        = r_vsel;
  assign loada       = r_loada;
  assign loadb       = r_loadb;
  assign asel        = r_asel;
  assign bsel        = 1'b0;
  assign loadc       = r_loadc;
  assign loads       = r_loads;
  assign shift       = r_shift;
  assign ALUop       = r_alu_op;
  assign datapath_in = {{(IW-8){r_ir[7]}}, r_ir[7:0]};
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven per-cycle check of controller outputs plus a behavioural datapath
module tb_cpu_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset(reset), .in(din), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .shift(shift), .ALUop(ALUop),
    .datapath_in(datapath_in)
  );

  typedef struct packed {
    logic        w;
    logic [2:0]  rdn;
    logic [2:0]  wrn;
    logic        wr;
    logic        vs;
    logic        la;
    logic        lb;
    logic        as;
    logic        bs;
    logic        lc;
    logic        ls;
    logic [1:0]  sh;
    logic [1:0]  op;
    logic [15:0] dp;
  } ctrl_t;

  typedef struct {
    string       nm;
    logic        ld;
    logic        st;
    logic [15:0] in;
    ctrl_t       e;
  } vec_t;

  ctrl_t obs;
  assign obs = {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
                loadc, loads, shift, ALUop, datapath_in};

  // behavioural datapath fed by the controller outputs
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc;
  logic        rz;
  logic [15:0] bsh, ain, bin, alu;
  assign bsh = shift == 2'b01 ? {rb[14:0], 1'b0} : shift == 2'b10 ? {1'b0, rb[15:1]} :
               shift == 2'b11 ? {rb[15], rb[15:1]} : rb;
  assign ain = asel ? 16'h0 : ra;
  assign bin = bsel ? datapath_in : bsh;
  assign alu = ALUop == 2'b00 ? ain + bin : ALUop == 2'b01 ? ain - bin :
               ALUop == 2'b10 ? ain & bin : ~bin;
  always @(posedge clk) begin
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu;
    if (loads) rz <= alu == 16'h0;
    if (write) rf[writenum] <= vsel ? datapath_in : rc;
  end

  function automatic ctrl_t mk(logic w_, logic [2:0] rn_, logic [2:0] wn_, logic wr_, logic vs_,
                               logic la_, logic lb_, logic as_, logic lc_, logic ls_,
                               logic [1:0] sh_, logic [1:0] op_, logic [15:0] dp_);
    return {w_, rn_, wn_, wr_, vs_, la_, lb_, as_, 1'b0, lc_, ls_, sh_, op_, dp_};
  endfunction
  function automatic ctrl_t idle(logic [15:0] dp_);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp_);
  endfunction
  function automatic ctrl_t dec(logic [15:0] dp_);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp_);
  endfunction
  function automatic ctrl_t wimm(logic [2:0] n, logic [15:0] dp_);
    return mk(0, 0, n, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp_);
  endfunction
  function automatic ctrl_t ga(logic [2:0] n, logic [15:0] dp_);
    return mk(0, n, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, dp_);
  endfunction
  function automatic ctrl_t gb(logic [2:0] n, logic [15:0] dp_);
    return mk(0, n, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, dp_);
  endfunction
  function automatic ctrl_t alus(logic [1:0] sh_, logic [1:0] op_, logic as_, logic lc_, logic [15:0] dp_);
    return mk(0, 0, 0, 0, 0, 0, 0, as_, lc_, 1, sh_, op_, dp_);
  endfunction
  function automatic ctrl_t wreg(logic [2:0] n, logic [15:0] dp_);
    return mk(0, 0, n, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp_);
  endfunction

  task automatic chk(input string nm, input ctrl_t got, input ctrl_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  vec_t v[$];
  task automatic add(input string nm, input logic ld, input logic st, input logic [15:0] in_, input ctrl_t e);
    vec_t t;
    t.nm = nm; t.ld = ld; t.st = st; t.in = in_; t.e = e;
    v.push_back(t);
  endtask

  task automatic step(input logic ld, input logic st, input logic [15:0] in_);
    load = ld; s = st; din = in_;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; s = 1'b0; din = 16'h0;
    // MOV R0,#7 and MOV R1,#-2, each loaded together with s
    add("movi0_dec", 1, 1, 16'hD007, dec(16'h0007));
    add("movi0_wimm", 0, 0, 16'h0, wimm(3'd0, 16'h0007));
    add("movi0_wait", 0, 0, 16'h0, idle(16'h0007));
    add("movi1_dec", 1, 1, 16'hD1FE, dec(16'hFFFE));
    add("movi1_wimm", 0, 0, 16'h0, wimm(3'd1, 16'hFFFE));
    add("movi1_wait", 0, 0, 16'h0, idle(16'hFFFE));
    // ADD R2,R1,R0,LSL#1 with load asserted while busy (must be ignored)
    add("add_dec", 1, 1, 16'hA148, dec(16'h0048));
    add("add_geta", 1, 0, 16'hFFFF, ga(3'd1, 16'h0048));
    add("add_getb", 1, 0, 16'hFFFF, gb(3'd0, 16'h0048));
    add("add_alu", 0, 0, 16'h0, alus(2'b01, 2'b00, 0, 1, 16'h0048));
    add("add_wreg", 0, 0, 16'h0, wreg(3'd2, 16'h0048));
    add("add_wait", 0, 0, 16'h0, idle(16'h0048));
    // CMP R1,R0: no write cycle
    add("cmp_dec", 1, 1, 16'hA900, dec(16'h0000));
    add("cmp_geta", 0, 0, 16'h0, ga(3'd1, 16'h0000));
    add("cmp_getb", 0, 0, 16'h0, gb(3'd0, 16'h0000));
    add("cmp_alu", 0, 0, 16'h0, alus(2'b00, 2'b01, 0, 0, 16'h0000));
    add("cmp_wait", 0, 0, 16'h0, idle(16'h0000));
    // MVN R3,R1,LSR#1
    add("mvn_dec", 1, 1, 16'hB871, dec(16'h0071));
    add("mvn_getb", 0, 0, 16'h0, gb(3'd1, 16'h0071));
    add("mvn_alu", 0, 0, 16'h0, alus(2'b10, 2'b11, 1, 1, 16'h0071));
    add("mvn_wreg", 0, 0, 16'h0, wreg(3'd3, 16'h0071));
    add("mvn_wait", 0, 0, 16'h0, idle(16'h0071));
    // MOV R4,R2,ASR#1
    add("movr_dec", 1, 1, 16'hC09A, dec(16'hFF9A));
    add("movr_getb", 0, 0, 16'h0, gb(3'd2, 16'hFF9A));
    add("movr_alu", 0, 0, 16'h0, alus(2'b11, 2'b00, 1, 1, 16'hFF9A));
    add("movr_wreg", 0, 0, 16'h0, wreg(3'd4, 16'hFF9A));
    add("movr_wait", 0, 0, 16'h0, idle(16'hFF9A));
    // AND R5,R3,R4
    add("and_dec", 1, 1, 16'hB3A4, dec(16'hFFA4));
    add("and_geta", 0, 0, 16'h0, ga(3'd3, 16'hFFA4));
    add("and_getb", 0, 0, 16'h0, gb(3'd4, 16'hFFA4));
    add("and_alu", 0, 0, 16'h0, alus(2'b00, 2'b10, 0, 1, 16'hFFA4));
    add("and_wreg", 0, 0, 16'h0, wreg(3'd5, 16'hFFA4));
    add("and_wait", 0, 0, 16'h0, idle(16'hFFA4));
    // illegal encodings return straight to WAIT
    add("ill_e000_dec", 1, 1, 16'hE000, dec(16'h0000));
    add("ill_e000_wait", 0, 0, 16'h0, idle(16'h0000));
    add("ill_c800_dec", 1, 1, 16'hC800, dec(16'h0000));
    add("ill_c800_wait", 0, 0, 16'h0, idle(16'h0000));
    // load alone in WAIT, then s held high across two back-to-back runs
    add("ldonly_wait", 1, 0, 16'hD605, idle(16'h0005));
    add("shold_dec", 0, 1, 16'h0, dec(16'h0005));
    add("shold_wimm", 0, 1, 16'h0, wimm(3'd6, 16'h0005));
    add("shold_wait", 0, 1, 16'h0, idle(16'h0005));
    add("shold_dec2", 0, 1, 16'h0, dec(16'h0005));
    add("shold_wimm2", 0, 0, 16'h0, wimm(3'd6, 16'h0005));
    add("shold_wait2", 0, 0, 16'h0, idle(16'h0005));

    repeat (2) @(posedge clk);
    #1 chk("reset_held", obs, idle(16'h0));
    reset = 1'b0;
    @(posedge clk); #1 chk("after_reset", obs, idle(16'h0));

    foreach (v[i]) begin
      step(v[i].ld, v[i].st, v[i].in);
      chk(v[i].nm, obs, v[i].e);
    end
    load = 1'b0; s = 1'b0;

    chk16("dp_r0", rf[0], 16'h0007);
    chk16("dp_r1", rf[1], 16'hFFFE);
    chk16("dp_r2", rf[2], 16'h000C);
    chk16("dp_r3", rf[3], 16'h8000);
    chk16("dp_r4", rf[4], 16'h0006);
    chk16("dp_r5", rf[5], 16'h0000);
    chk16("dp_r6", rf[6], 16'h0005);
    chk16("dp_z", {15'h0, rz}, 16'h0001);

    // asynchronous reset in GET_B of ADD
    step(1, 1, 16'hA148);
    step(0, 0, 16'h0);
    step(0, 0, 16'h0);
    chk("rst1_pre_getb", obs, gb(3'd0, 16'h0048));
    #2 reset = 1'b1;
    #1 chk("rst1_mid_getb", obs, idle(16'h0));
    reset = 1'b0;
    @(posedge clk); #1 chk("rst1_after", obs, idle(16'h0));

    // asynchronous reset in WR_REG drops write without a clock edge
    step(1, 1, 16'hA148);
    repeat (4) step(0, 0, 16'h0);
    chk("rst2_pre_wreg", obs, wreg(3'd2, 16'h0048));
    #2 reset = 1'b1;
    #1 chk("rst2_mid_wreg", obs, idle(16'h0));
    reset = 1'b0;
    @(posedge clk); #1 chk("rst2_after", obs, idle(16'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
